async_fifo_rd_ctrl: RTL
=======================

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter PTR_LEN, default 4, memory address width; FIFO depth = 2**PTR_LEN, pointers are PTR_LEN+1 bits.
REQ-003 SHALL have port rd_clk  input  1  read-domain clock, the only clock.
REQ-004 SHALL have port rd_arstn  input  1  asynchronous active-low reset; one clock, asynchronous active-low reset.
REQ-005 SHALL have port wr_ptr_gray  input  PTR_LEN+1  write pointer, Gray-coded, driven from the write clock domain.
REQ-006 SHALL have port mem_data  input  WIDTH  combinational read data from the FIFO memory at rd_ptr.
REQ-007 SHALL have port rd_ptr  output  PTR_LEN+1  binary read pointer to the memory; low PTR_LEN bits address it.
REQ-008 SHALL have port rd_en  output  1  memory read enable.
REQ-009 SHALL have port rd_ptr_gray  output  PTR_LEN+1  registered Gray read pointer for the write-domain full logic.
REQ-010 SHALL have port m_data  output  WIDTH  output word.
REQ-011 SHALL have port m_valid  output  1  m_data holds a valid word.
REQ-012 SHALL have port m_ready  input  1  consumer accepts m_data.
REQ-013 SHALL have port empty  output  1  memory holds no unread word (synchronized view).
REQ-014 SHALL have port rd_count  output  PTR_LEN+1  words held in memory, excluding the output register.

Function
REQ-015 SHALL pass wr_ptr_gray through a two-flop synchronizer (wsync1, wsync2) in rd_clk; no other logic on wr_ptr_gray before wsync2.
REQ-016 SHALL convert wsync2 to binary (wr_bin_sync) via XOR-prefix Gray-to-binary.
REQ-017 SHALL drive empty = (rd_ptr_gray == wsync2), combinationally from registers.
REQ-018 SHALL drive rd_en = ~empty.
REQ-019 SHALL define load = ~empty & (~m_valid | m_ready).
REQ-020 On load, SHALL register m_data <= mem_data, set m_valid <= 1, rd_ptr <= rd_ptr+1, rd_ptr_gray <= bin2gray(rd_ptr+1), all on the same edge.
REQ-021 When m_valid & m_ready & empty, SHALL clear m_valid; m_data keeps last value.
REQ-022 When m_valid & ~m_ready, SHALL hold m_data and m_valid unchanged, no pointer advance.
REQ-023 Output states: IDLE (m_valid=0) -> FULL on load; FULL -> FULL on m_ready & load; FULL -> IDLE on m_ready & empty; FULL held on ~m_ready.
REQ-024 Sustained throughput SHALL be one word per rd_clk while ~empty and m_ready=1.
REQ-025 Latency: wr_ptr_gray change to m_valid rise SHALL be 3 rd_clk edges (2 sync + 1 load) when idle.
REQ-026 rd_ptr and rd_ptr_gray SHALL wrap modulo 2**(PTR_LEN+1); 2**(PTR_LEN+1)-1 increments to 0.
REQ-027 SHALL drive rd_count = (wr_bin_sync - rd_ptr) mod 2**(PTR_LEN+1); valid range 0..2**PTR_LEN.
REQ-028 SHALL never advance rd_ptr while empty=1 (no underflow, regardless of m_ready).
REQ-029 rd_ptr_gray SHALL change by exactly one bit per advance and be a flop output (glitch-free crossing).

Reset
REQ-030 On rd_arstn=0, SHALL asynchronously clear rd_ptr, rd_ptr_gray, wsync1, wsync2, m_data, m_valid to 0; empty=1, rd_count=0, rd_en=0 follow.
REQ-031 Reset asserted mid-transfer SHALL discard m_data/m_valid immediately; no load on the deasserting edge's cycle beyond normal rules.
REQ-032 After rd_arstn rises, first load SHALL require wsync2 to differ from 0 per REQ-015..020.

Verification
REQ-033 Reset: hold rd_arstn=0, wr_ptr_gray=5'b00011 -> m_valid=0, rd_ptr=0, empty=1, rd_count=0; after release wsync2 carries 00011 after 2 edges.
REQ-034 Single word: from reset, wr_ptr_gray 0->1, mem_data=8'hA5, m_ready=0 -> m_valid=1, m_data=A5 at 3rd edge; rd_ptr=1, rd_ptr_gray=1, empty=1; held until m_ready=1, then m_valid=0 next edge.
REQ-035 Streaming: wr_ptr_gray = gray(16) (full, PTR_LEN=4), m_ready=1 -> 16 consecutive words, one per cycle, rd_count 16->0, rd_ptr ends 16 (gray 5'b11000).
REQ-036 Backpressure: m_ready toggles 1,0,0,1 with 4 words available -> m_data stable during m_ready=0, no word lost or duplicated, rd_ptr advances only on load.
REQ-037 Wrap: preload rd_ptr=31 path (write 32 words total in two batches) -> rd_ptr 31->0, rd_ptr_gray 5'b10000->5'b00000, empty asserted correctly, rd_count never exceeds 16.
REQ-038 Mid-operation reset: assert rd_arstn=0 asynchronously while m_valid=1, rd_ptr=7 -> all outputs zero before next rd_clk edge.

Source files
------------

// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl: read-side controller of an async FIFO with a registered output stage.
// The write pointer is resynchronized into rd_clk; the read pointer leaves as a flopped Gray code.
module async_fifo_rd_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PTR_LEN = 4
) (
    input  logic               rd_clk,
    input  logic               rd_arstn,
    input  logic [PTR_LEN:0]   wr_ptr_gray,
    input  logic [WIDTH-1:0]   mem_data,
    output logic [PTR_LEN:0]   rd_ptr,
    output logic               rd_en,
    output logic [PTR_LEN:0]   rd_ptr_gray,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               empty,
    output logic [PTR_LEN:0]   rd_count
);
    logic [PTR_LEN:0] r_wsync1;
    logic [PTR_LEN:0] r_wsync2;
    logic [PTR_LEN:0] r_rd_ptr;
    logic [PTR_LEN:0] r_rd_ptr_gray;
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;
    logic [PTR_LEN:0] w_wr_bin_sync;
    logic [PTR_LEN:0] w_rd_ptr_nxt;
    logic             w_empty;
    logic             w_load;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= PTR_LEN; i++) begin : g_g2b
        assign w_wr_bin_sync[i] = ^(r_wsync2 >> i);
    end

    assign w_empty      = r_rd_ptr_gray == r_wsync2;
    assign w_load       = ~w_empty & (~r_m_valid | m_ready);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge rd_clk or negedge rd_arstn) begin
        if (!rd_arstn) begin
            r_wsync1      <= '0;
            r_wsync2      <= '0;
            r_rd_ptr      <= '0;
            r_rd_ptr_gray <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
        end else begin
            r_wsync1  <= wr_ptr_gray;
            r_wsync2  <= r_wsync1;
            r_m_valid <= w_load | (r_m_valid & ~m_ready);
            if (w_load) begin
                r_m_data      <= mem_data;
                r_rd_ptr      <= w_rd_ptr_nxt;
                r_rd_ptr_gray <= w_rd_ptr_nxt ^ (w_rd_ptr_nxt >> 1);
            end
        end
    end

    assign rd_ptr      = r_rd_ptr;
    assign rd_ptr_gray = r_rd_ptr_gray;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign empty       = w_empty;
    assign rd_en       = ~w_empty;
    assign rd_count    = w_wr_bin_sync - r_rd_ptr;
endmodule
